// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan controller: digit count, "off"
// codes, the scan state type and the hex-to-segment lookup.
package seg_pkg;

  localparam int         NUM_DIGITS = 6;
  localparam logic [7:0] SEG_OFF    = 8'hFF;
  localparam logic [2:0] DIG_NONE   = 3'b111;

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } scan_state_t;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble (A,b,C,d,E,F above 9).
  function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_hex_encoder.sv
// Combinational nibble + decimal point -> active-low {dp,g,f,e,d,c,b,a}.
// blank forces segments a-g off while leaving the dp bit untouched.
module seg_hex_encoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg_data
);

  // dp is active-low like the segments; blank only affects a-g.
  always_comb begin
    seg_data = {~dp, (blank ? 7'h7F : hex2seg(nibble))};
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a 6-digit 7-segment display.
// Each digit slot is BLANK_CYC dark cycles followed by SCAN_DIV-BLANK_CYC lit
// cycles. Frame data is double buffered: loads land in a pending register and
// move to the display register only at the frame boundary (digit 5 -> 0) or
// while the display is disabled, so a frame never tears.
// Optional build macro: SEG_LZ_SUPPRESS_EN enables leading-zero suppression.
//
// Load handshake: a load is accepted on a clock edge where load_valid and
// load_ready are both 1. load_ready is 1 exactly when the pending register is
// empty; it drops the cycle after an accept and rises the cycle after the
// pending data moves to the display register.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [23:0] load_data,
  input  logic [5:0]  load_dp,
  output logic [2:0]  bit_disp,
  output logic [7:0]  seg_data,
  output logic        frame_tick,
  output scan_state_t dbg_state
);

  localparam int              CW         = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]   BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0]   SHOW_LAST  = CW'(SCAN_DIV - BLANK_CYC - 1);
  localparam logic [2:0]      LAST_DIGIT = 3'(NUM_DIGITS - 1);

  scan_state_t   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    digit, digit_nxt;
  logic          wrap;

  logic [23:0]   disp_data, pend_data, disp_data_nxt;
  logic [5:0]    disp_dp, pend_dp, disp_dp_nxt;
  logic          accept, xfer;

  logic [3:0]    sel_nib;
  logic          sel_dp;
  logic          seg_blank;
  logic [7:0]    enc_seg;

  assign dbg_state = state;

  // Scan FSM registers: state, slot counter and current digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_BLANK;
      cnt   <= '0;
      digit <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      digit <= digit_nxt;
    end
  end

  // Next-state logic: BLANK -> SHOW -> next digit's BLANK; disable parks at digit 0 BLANK.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    digit_nxt = digit;
    wrap      = 1'b0;
    if (!enable) begin
      state_nxt = ST_BLANK;
      cnt_nxt   = '0;
      digit_nxt = '0;
    end else begin
      case (state)
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nxt = ST_SHOW;
            cnt_nxt   = '0;
          end
        end
        default: begin
          if (cnt == SHOW_LAST) begin
            state_nxt = ST_BLANK;
            cnt_nxt   = '0;
            if (digit == LAST_DIGIT) begin
              digit_nxt = '0;
              wrap      = 1'b1;
            end else begin
              digit_nxt = digit + 3'd1;
            end
          end
        end
      endcase
    end
  end

  // Transfer only moves real pending data; an empty pending register never
  // overwrites what is on the display.
  always_comb begin
    accept        = load_valid & load_ready;
    xfer          = ~load_ready & (wrap | ~enable);
    disp_data_nxt = xfer ? pend_data : disp_data;
    disp_dp_nxt   = xfer ? pend_dp   : disp_dp;
  end

  // Double buffer: pending register, display register and the ready flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_data  <= '0;
      pend_dp    <= '0;
      disp_data  <= '0;
      disp_dp    <= '0;
      load_ready <= 1'b1;
    end else begin
      disp_data <= disp_data_nxt;
      disp_dp   <= disp_dp_nxt;
      if (accept) begin
        pend_data  <= load_data;
        pend_dp    <= load_dp;
        load_ready <= 1'b0;
      end else if (xfer) begin
        load_ready <= 1'b1;
      end
    end
  end

  // Pick the nibble and dp of the digit that will be lit next cycle.
  always_comb begin
    sel_nib = '0;
    sel_dp  = 1'b0;
    case (digit_nxt)
      3'd0: begin sel_nib = disp_data_nxt[23:20]; sel_dp = disp_dp_nxt[5]; end
      3'd1: begin sel_nib = disp_data_nxt[19:16]; sel_dp = disp_dp_nxt[4]; end
      3'd2: begin sel_nib = disp_data_nxt[15:12]; sel_dp = disp_dp_nxt[3]; end
      3'd3: begin sel_nib = disp_data_nxt[11:8];  sel_dp = disp_dp_nxt[2]; end
      3'd4: begin sel_nib = disp_data_nxt[7:4];   sel_dp = disp_dp_nxt[1]; end
      3'd5: begin sel_nib = disp_data_nxt[3:0];   sel_dp = disp_dp_nxt[0]; end
      default: begin sel_nib = '0; sel_dp = 1'b0; end
    endcase
  end

`ifdef SEG_LZ_SUPPRESS_EN
  logic [7:0] lz_zero;

  // lz_zero[i] is set when nibbles 0..i (from the left) are all zero.
  always_comb begin
    lz_zero    = '0;
    lz_zero[0] = (disp_data_nxt[23:20] == 4'd0);
    for (int i = 1; i < NUM_DIGITS; i++) begin
      lz_zero[i] = lz_zero[i-1] & (disp_data_nxt[23-4*i -: 4] == 4'd0);
    end
  end

  // The rightmost digit always shows, so a value of zero still reads "0".
  assign seg_blank = (digit_nxt != LAST_DIGIT) & lz_zero[digit_nxt];
`else
  assign seg_blank = 1'b0;
`endif

  seg_hex_encoder u_enc (
    .nibble   (sel_nib),
    .dp       (sel_dp),
    .blank    (seg_blank),
    .seg_data (enc_seg)
  );

  // Registered outputs follow the next state so they line up with the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_disp   <= DIG_NONE;
      seg_data   <= SEG_OFF;
      frame_tick <= 1'b0;
    end else begin
      bit_disp   <= (state_nxt == ST_SHOW) ? digit_nxt : DIG_NONE;
      seg_data   <= (state_nxt == ST_SHOW) ? enc_seg   : SEG_OFF;
      frame_tick <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (SCAN_DIV=8, BLANK_CYC=2).
// The reference model tracks the position inside a 48-cycle frame plus the
// pending/display buffers and derives every output from that position.
module tb_seg_scan_ctrl;
  import seg_pkg::*;

  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 6 * SD;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        load_valid = 1'b0;
  logic [23:0] load_data = '0;
  logic [5:0]  load_dp = '0;
  logic        load_ready;
  logic [2:0]  bit_disp;
  logic [7:0]  seg_data;
  logic        frame_tick;
  scan_state_t dbg_state;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_dp    (load_dp),
    .bit_disp   (bit_disp),
    .seg_data   (seg_data),
    .frame_tick (frame_tick),
    .dbg_state  (dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int          m_pos;
  logic [23:0] m_disp, m_pend;
  logic [5:0]  m_dpd, m_dpp;
  bit          m_full, m_tick;

  function automatic logic [6:0] ref_seg7(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  task automatic model_step();
    bit acc, wrap;
    if (rst) begin
      m_pos = 0; m_disp = '0; m_pend = '0; m_dpd = '0; m_dpp = '0;
      m_full = 0; m_tick = 0;
    end else begin
      acc  = load_valid && !m_full;
      wrap = enable && (m_pos == FRAME - 1);
      if (m_full && (wrap || !enable)) begin
        m_disp = m_pend; m_dpd = m_dpp; m_full = 0;
      end
      if (acc) begin
        m_pend = load_data; m_dpp = load_dp; m_full = 1;
      end
      m_tick = wrap;
      m_pos  = (!enable || wrap) ? 0 : m_pos + 1;
    end
  endtask

  task automatic model_compare();
    int slot, off;
    bit show, lz;
    logic [3:0] nib;
    logic [2:0] e_bit;
    logic [7:0] e_seg;
    slot = m_pos / SD;
    off  = m_pos % SD;
    show = (off >= BC);
    nib  = m_disp[23 - 4*slot -: 4];
    lz   = 1'b0;
`ifdef SEG_LZ_SUPPRESS_EN
    lz   = (slot < 5) && ((m_disp >> (4 * (5 - slot))) == 24'd0);
`endif
    e_bit = show ? 3'(slot) : 3'b111;
    e_seg = show ? {~m_dpd[5 - slot], (lz ? 7'h7F : ref_seg7(nib))} : 8'hFF;
    check("bit_disp",   32'(bit_disp),   32'(e_bit));
    check("seg_data",   32'(seg_data),   32'(e_seg));
    check("load_ready", 32'(load_ready), 32'(!m_full));
    check("frame_tick", 32'(frame_tick), 32'(m_tick));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick_cycle();
    @(posedge clk);
    model_step();
    #1;
    model_compare();
  endtask

  task automatic wait_tick(input int bound);
    int n = 0;
    while (!frame_tick && n < bound) begin tick_cycle(); n++; end
    if (!frame_tick) check("wait_tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_digit(input logic [2:0] d, input int bound);
    int n = 0;
    while (bit_disp !== d && n < bound) begin tick_cycle(); n++; end
    if (bit_disp !== d) check("wait_digit_timeout", 32'(bit_disp), 32'(d));
  endtask

  task automatic load_once(input logic [23:0] d, input logic [5:0] p);
    int n = 0;
    bit done = 0;
    load_valid = 1'b1; load_data = d; load_dp = p;
    while (!done && n < 200) begin
      done = load_ready;
      tick_cycle();
      n++;
    end
    load_valid = 1'b0;
    if (!done) check("load_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // 1. reset
    rst = 1'b1;
    tick_cycle(); tick_cycle();
    check("rst_bit_disp",   32'(bit_disp),   32'h7);
    check("rst_seg_data",   32'(seg_data),   32'hFF);
    check("rst_load_ready", 32'(load_ready), 32'h1);
    check("rst_frame_tick", 32'(frame_tick), 32'h0);
    rst = 1'b0;
    enable = 1'b1;

    // 2. single load, visible after next frame boundary
    load_once(24'h123456, 6'b000000);
    check("ready_drop", 32'(load_ready), 32'h0);
    wait_tick(200);
    wait_digit(3'd0, 20);
    check("d0_is_1", 32'(seg_data), 32'hF9);
    wait_digit(3'd1, 20);
    check("d1_is_2", 32'(seg_data), 32'hA4);

    // 3. back-to-back loads
    load_once(24'hABCDEF, 6'b000000);
    check("b2b_ready_low", 32'(load_ready), 32'h0);
    load_once(24'h987654, 6'b000000);
    wait_digit(3'd0, 20);
    check("frame_data1", 32'(seg_data), 32'h88);
    wait_tick(200);
    wait_digit(3'd0, 20);
    check("frame_data2", 32'(seg_data), 32'h90);

    // 4. drop enable mid-SHOW on digit 3
    wait_digit(3'd3, 100);
    tick_cycle();
    enable = 1'b0;
    tick_cycle();
    check("dis_bit_disp", 32'(bit_disp), 32'h7);
    check("dis_seg_data", 32'(seg_data), 32'hFF);
    tick_cycle(); tick_cycle();
    enable = 1'b1;
    tick_cycle();
    check("reen_blank", 32'(bit_disp), 32'h7);
    tick_cycle();
    check("reen_digit0", 32'(bit_disp), 32'h0);

    // 5. leading zeros
    load_once(24'h000120, 6'b000000);
    wait_tick(200);
    wait_digit(3'd0, 20);
`ifdef SEG_LZ_SUPPRESS_EN
    check("lz_d0", 32'(seg_data), 32'hFF);
`else
    check("lz_d0", 32'(seg_data), 32'hC0);
`endif
    wait_digit(3'd3, 40);
    check("lz_d3", 32'(seg_data), 32'hF9);
    wait_digit(3'd5, 40);
    check("lz_d5", 32'(seg_data), 32'hC0);

    // 6. nibble A with dp, then reset mid-SHOW
    load_once(24'hA00000, 6'b100000);
    wait_tick(200);
    wait_digit(3'd0, 20);
    check("a_dp", 32'(seg_data), 32'h08);
    tick_cycle();
    rst = 1'b1;
    tick_cycle();
    check("mid_rst_bit_disp",   32'(bit_disp),   32'h7);
    check("mid_rst_seg_data",   32'(seg_data),   32'hFF);
    check("mid_rst_load_ready", 32'(load_ready), 32'h1);
    check("mid_rst_frame_tick", 32'(frame_tick), 32'h0);
    rst = 1'b0;

    // 7. randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      load_valid = ($urandom_range(0, 19) == 0);
      load_data  = 24'($urandom);
      load_dp    = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) load_data[23:12] = '0;
      tick_cycle();
    end
    rst = 1'b0; load_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
